// File: rtl/tdc_trace_ctrl.sv
// tdc_trace_ctrl: capture sequencer for the carry-chain TDC sensor.
// Arms on command, waits for a fresh rising edge of the ESP trigger, compresses
// each accepted TAPS-wide thermometer snapshot to a popcount (keeping one of every
// decim+1 valid snapshots), records len samples in an on-chip buffer and drains
// them over a valid/ready stream.
// Ports:
//   clk_capture, rst_n        capture clock, async active-low reset
//   tdc_data, tdc_valid       sensor snapshot and its qualifier
//   esp_trigger               asynchronous trigger (synchronised internally)
//   arm, abort                one-cycle command pulses
//   cfg_len, cfg_decim        trace length / decimation, latched on arm
//   out_data/valid/ready/last sample stream towards the host link
//   busy, done                status: not idle / trace handed off
module tdc_trace_ctrl #(
  parameter int unsigned DEPTH = 1024,
  parameter int unsigned TAPS  = 64,
  parameter int unsigned CNT_W = 8
) (
  input  logic                     clk_capture,
  input  logic                     rst_n,
  input  logic [TAPS-1:0]          tdc_data,
  input  logic                     tdc_valid,
  input  logic                     esp_trigger,
  input  logic                     arm,
  input  logic                     abort,
  input  logic [$clog2(DEPTH):0]   cfg_len,
  input  logic [7:0]               cfg_decim,
  output logic [CNT_W-1:0]         out_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic                     out_last,
  output logic                     busy,
  output logic                     done
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned LW  = AW + 1;
  localparam int unsigned GRP = TAPS / 8;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);
  localparam logic [LW-1:0] ONE_L   = LW'(1);

  typedef enum logic [2:0] {IDLE, ARMED, CAPTURE, FLUSH, DRAIN} state_t;

  state_t state;

  logic trig_s1, trig_s2, trig_prev, trig_rise_q;

  logic [LW-1:0] len_q;
  logic [7:0]    decim_q;
  logic [7:0]    dec_cnt;
  logic [LW-1:0] acc_cnt;
  logic [LW-1:0] wr_ptr;
  logic [LW-1:0] rd_ptr;

  logic             s1_valid, s2_valid;
  logic [3:0]       s1_part [GRP];
  logic [CNT_W-1:0] s2_sum;

  logic [CNT_W-1:0] mem [DEPTH];
  logic [CNT_W-1:0] rd_q;
  logic             rd_v;
  logic             rd_last;

  logic [3:0]       part_c [GRP];
  logic [CNT_W-1:0] sum_c;
  logic             accept_c;
  logic             rd_take;
  logic             rd_issue;

  // Stage 1: one partial popcount per byte of the snapshot.
  always_comb begin
    for (int unsigned g = 0; g < GRP; g++) begin
      part_c[g] = '0;
      for (int unsigned b = 0; b < 8; b++) begin
        part_c[g] = part_c[g] + 4'(tdc_data[g*8 + b]);
      end
    end
  end

  // Stage 2: sum of the registered partials.
  always_comb begin
    sum_c = '0;
    for (int unsigned g = 0; g < GRP; g++) begin
      sum_c = sum_c + CNT_W'(s1_part[g]);
    end
  end

  always_comb begin
    accept_c = (state == CAPTURE) && tdc_valid && (dec_cnt == '0);
    // Read stage feeds the output register; it can refill in the same cycle it
    // is emptied, which keeps one sample per cycle with a 1-cycle read latency.
    rd_take  = rd_v && (!out_valid || out_ready);
    rd_issue = (state == DRAIN) && (rd_ptr != len_q) && (!rd_v || rd_take);
  end

  // Datapath and trace buffer: no reset, contents survive reset and abort.
  always_ff @(posedge clk_capture) begin
    if (accept_c) begin
      for (int unsigned g = 0; g < GRP; g++) begin
        s1_part[g] <= part_c[g];
      end
    end
    if (s1_valid) begin
      s2_sum <= sum_c;
    end
    if (s2_valid) begin
      mem[wr_ptr[AW-1:0]] <= s2_sum;
    end
    if (rd_issue) begin
      rd_q <= mem[rd_ptr[AW-1:0]];
    end
  end

  always_ff @(posedge clk_capture or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      trig_s1     <= 1'b0;
      trig_s2     <= 1'b0;
      trig_prev   <= 1'b0;
      trig_rise_q <= 1'b0;
      len_q       <= '0;
      decim_q     <= '0;
      dec_cnt     <= '0;
      acc_cnt     <= '0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      s1_valid    <= 1'b0;
      s2_valid    <= 1'b0;
      rd_v        <= 1'b0;
      rd_last     <= 1'b0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
    end else begin
      trig_s1     <= esp_trigger;
      trig_s2     <= trig_s1;
      trig_prev   <= trig_s2;
      trig_rise_q <= trig_s2 & ~trig_prev;

      done     <= 1'b0;
      s1_valid <= accept_c;
      s2_valid <= s1_valid;
      if (s2_valid) begin
        wr_ptr <= wr_ptr + ONE_L;
      end

      if (abort) begin
        state     <= IDLE;
        busy      <= 1'b0;
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        s1_valid  <= 1'b0;
        s2_valid  <= 1'b0;
        rd_v      <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (arm) begin
              state   <= ARMED;
              busy    <= 1'b1;
              len_q   <= ((cfg_len == '0) || (cfg_len > DEPTH_L)) ? DEPTH_L : cfg_len;
              decim_q <= cfg_decim;
              acc_cnt <= '0;
              wr_ptr  <= '0;
              rd_ptr  <= '0;
            end
          end
          ARMED: begin
            if (trig_rise_q) begin
              state   <= CAPTURE;
              dec_cnt <= '0;
            end
          end
          CAPTURE: begin
            if (tdc_valid) begin
              dec_cnt <= (dec_cnt == decim_q) ? 8'd0 : dec_cnt + 8'd1;
            end
            if (accept_c) begin
              acc_cnt <= acc_cnt + ONE_L;
              if (acc_cnt + ONE_L == len_q) begin
                state <= FLUSH;
              end
            end
          end
          FLUSH: begin
            if (wr_ptr == len_q) begin
              state <= DRAIN;
            end
          end
          DRAIN: begin
            if (rd_issue) begin
              rd_ptr  <= rd_ptr + ONE_L;
              rd_v    <= 1'b1;
              rd_last <= (rd_ptr == len_q - ONE_L);
            end else if (rd_take) begin
              rd_v <= 1'b0;
            end

            if (out_valid && out_ready && out_last) begin
              state     <= IDLE;
              busy      <= 1'b0;
              done      <= 1'b1;
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end else if (rd_take) begin
              out_valid <= 1'b1;
              out_data  <= rd_q;
              out_last  <= rd_last;
            end else if (out_valid && out_ready) begin
              out_valid <= 1'b0;
              out_last  <= 1'b0;
            end
          end
          default: begin
            state <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_tdc_trace_ctrl.sv
module tb_tdc_trace_ctrl;

  localparam int DEPTH = 1024;
  localparam int TAPS  = 64;
  localparam int CNT_W = 8;

  logic              clk_capture = 1'b0;
  logic              rst_n       = 1'b0;
  logic [TAPS-1:0]   tdc_data    = '0;
  logic              tdc_valid   = 1'b0;
  logic              esp_trigger = 1'b0;
  logic              arm         = 1'b0;
  logic              abort       = 1'b0;
  logic [10:0]       cfg_len     = '0;
  logic [7:0]        cfg_decim   = '0;
  logic [CNT_W-1:0]  out_data;
  logic              out_valid;
  logic              out_ready   = 1'b1;
  logic              out_last;
  logic              busy;
  logic              done;

  tdc_trace_ctrl #(.DEPTH(DEPTH), .TAPS(TAPS), .CNT_W(CNT_W)) dut (
    .clk_capture (clk_capture),
    .rst_n       (rst_n),
    .tdc_data    (tdc_data),
    .tdc_valid   (tdc_valid),
    .esp_trigger (esp_trigger),
    .arm         (arm),
    .abort       (abort),
    .cfg_len     (cfg_len),
    .cfg_decim   (cfg_decim),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_last    (out_last),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk_capture = ~clk_capture;

  int pass_cnt  = 0;
  int total_cnt = 0;
  int done_cnt  = 0;
  int rdy_mode  = 0;   // 0: ready high, 1: pattern, 2: ready low
  int expq[$];         // {last, data[15:0]}
  int feed_q[$];

  task automatic chk(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [63:0] ones(input int n);
    logic [63:0] v;
    v = '0;
    for (int i = 0; i < n; i++) v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk_capture);
    #1;
  endtask

  task automatic expect_s(input int d, input int last);
    expq.push_back(d | (last << 16));
  endtask

  task automatic arm_trace(input int len, input int decim);
    cfg_len   = 11'(len);
    cfg_decim = 8'(decim);
    arm = 1'b1;
    tick();
    arm = 1'b0;
    chk("busy_after_arm", busy, 1);
  endtask

  // Trigger rises before edge k; the first eligible snapshot is sampled at k+4.
  // The four earlier cycles carry popcounts 60..57 when pre_valid is set.
  task automatic trig_feed(input bit pre_valid);
    esp_trigger = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tdc_valid = pre_valid;
      tdc_data  = ones(60 - j);
      tick();
    end
    for (int i = 0; i < feed_q.size(); i++) begin
      tdc_valid = 1'b1;
      tdc_data  = ones(feed_q[i]);
      tick();
    end
    tdc_valid   = 1'b0;
    esp_trigger = 1'b0;
    feed_q.delete();
  endtask

  task automatic wait_done(input int budget);
    int start;
    int n;
    start = done_cnt;
    n = 0;
    while (done_cnt == start && n < budget) begin
      tick();
      n++;
    end
    chk("done_seen", done_cnt - start, 1);
    repeat (4) tick();
    chk("done_single_pulse", done_cnt - start, 1);
    chk("busy_idle_after", busy, 0);
    chk("stream_complete", expq.size(), 0);
    expq.delete();
  endtask

  // Ready driver
  initial begin
    int pat[6] = '{1, 0, 0, 1, 0, 1};
    int pi = 0;
    forever begin
      @(posedge clk_capture);
      #1;
      case (rdy_mode)
        0: out_ready = 1'b1;
        1: begin out_ready = pat[pi][0]; pi = (pi + 1) % 6; end
        default: out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pops the scoreboard on each handshake, checks stall stability.
  initial begin
    bit prev_stall = 0;
    logic [CNT_W-1:0] held_data = '0;
    logic held_last = 1'b0;
    int e;
    forever begin
      @(negedge clk_capture);
      if (!rst_n) begin
        prev_stall = 0;
      end else begin
        if (prev_stall) begin
          chk("stall_valid_held", out_valid, 1);
          chk("stall_data_stable", out_data, held_data);
          chk("stall_last_stable", out_last, held_last);
        end
        if (out_valid && out_ready) begin
          if (expq.size() == 0) begin
            total_cnt++;
            $display("FAIL unexpected_output: got data %0d last %0d, expected no output", out_data, out_last);
          end else begin
            e = expq.pop_front();
            chk("out_data", out_data, e & 16'hFFFF);
            chk("out_last", out_last, e >> 16);
          end
        end
        prev_stall = out_valid && !out_ready;
        held_data  = out_data;
        held_last  = out_last;
        if (done) begin
          done_cnt++;
          chk("busy_low_with_done", busy, 0);
        end
      end
    end
  end

  initial begin
    #400000;
    total_cnt++;
    $display("FAIL watchdog: got no finish, expected finish before timeout");
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    int start;
    int n;
    repeat (2) @(posedge clk_capture);
    #1;
    chk("rst_out_data", out_data, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    rst_n = 1'b1;
    repeat (2) tick();

    // Trigger pulse while idle
    esp_trigger = 1'b1;
    repeat (2) tick();
    esp_trigger = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("idle_trigger_busy", busy, 0);
    end

    // Basic trace
    arm_trace(4, 0);
    feed_q = '{4, 8, 12, 64};
    expect_s(4, 0); expect_s(8, 0); expect_s(12, 0); expect_s(64, 1);
    trig_feed(0);
    wait_done(100);
    repeat (4) tick();

    // Decimation with junk snapshots before the first eligible cycle
    arm_trace(3, 2);
    for (int i = 0; i < 9; i++) feed_q.push_back(i);
    expect_s(0, 0); expect_s(3, 0); expect_s(6, 1);
    trig_feed(1);
    wait_done(100);
    repeat (4) tick();

    // Backpressure
    rdy_mode = 1;
    arm_trace(4, 0);
    feed_q = '{4, 8, 12, 64};
    expect_s(4, 0); expect_s(8, 0); expect_s(12, 0); expect_s(64, 1);
    trig_feed(0);
    wait_done(200);
    rdy_mode = 0;
    repeat (4) tick();

    // Trigger already high at arm
    esp_trigger = 1'b1;
    repeat (5) tick();
    arm_trace(2, 0);
    for (int i = 0; i < 8; i++) begin
      tdc_valid = 1'b1;
      tdc_data  = ones(33);
      tick();
      chk("armed_hold_busy", busy, 1);
      chk("armed_hold_no_out", out_valid, 0);
    end
    tdc_valid   = 1'b0;
    esp_trigger = 1'b0;
    repeat (4) tick();
    feed_q = '{5, 7};
    expect_s(5, 0); expect_s(7, 1);
    trig_feed(0);
    wait_done(100);
    repeat (4) tick();

    // Abort in CAPTURE after two acceptances
    arm_trace(4, 0);
    feed_q = '{3, 4};
    trig_feed(0);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_out_last", out_last, 0);
    start = done_cnt;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("abort_no_output", out_valid, 0);
    end
    chk("abort_no_done", done_cnt - start, 0);

    // Abort and arm together
    cfg_len = 11'd4;
    arm     = 1'b1;
    abort   = 1'b1;
    tick();
    arm   = 1'b0;
    abort = 1'b0;
    chk("abort_beats_arm", busy, 0);
    repeat (4) tick();

    // Reset mid-DRAIN
    rdy_mode = 2;
    arm_trace(8, 0);
    feed_q = '{1, 2, 3, 4, 5, 6, 7, 8};
    trig_feed(0);
    n = 0;
    while (!out_valid && n < 50) begin
      tick();
      n++;
    end
    chk("drain_reached", out_valid, 1);
    @(posedge clk_capture);
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_out_valid", out_valid, 0);
    chk("async_rst_out_last", out_last, 0);
    chk("async_rst_out_data", out_data, 0);
    chk("async_rst_busy", busy, 0);
    chk("async_rst_done", done, 0);
    @(posedge clk_capture);
    #1;
    rst_n = 1'b1;
    rdy_mode = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      chk("post_rst_no_stream", out_valid, 0);
    end

    // Length boundary: cfg_len=0 records DEPTH samples
    arm_trace(0, 0);
    for (int i = 0; i < DEPTH; i++) begin
      feed_q.push_back(i % 65);
      expect_s(i % 65, (i == DEPTH - 1) ? 1 : 0);
    end
    trig_feed(0);
    wait_done(3000);
    repeat (4) tick();

    // Next trace restarts at entry 0
    arm_trace(2, 0);
    feed_q = '{9, 10};
    expect_s(9, 0); expect_s(10, 1);
    trig_feed(0);
    wait_done(100);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/tdc_trace_ctrl.md
# tdc_trace_ctrl

Capture sequencer for the carry-chain TDC sensor, running in the capture clock domain. It arms on command and waits for a rising edge of the ESP trigger. It then compresses each 64-tap thermometer snapshot to a popcount, keeps every (decim+1)-th sample, and stores the configured number of samples in an on-chip trace buffer. Finally it drains the buffer over a valid/ready stream to the host link (UART/FIFO side).

## Interface
- `DEPTH`, 1024: trace buffer entries; power of two, at least 2.
- `TAPS`, 64: width of the TDC snapshot.
- `CNT_W`, 8: width of a stored sample; must be at least $clog2(TAPS+1).
- `clk_capture` in 1: the single clock (TDC capture clock).
- `rst_n` in 1: asynchronous, active-low reset.
- `tdc_data` in TAPS: snapshot from the sensor.
- `tdc_valid` in 1: snapshot valid this cycle.
- `esp_trigger` in 1: asynchronous trigger from the ESP, high while AES runs.
- `arm` in 1: one-cycle pulse; starts a trace.
- `abort` in 1: one-cycle pulse; cancels the current trace.
- `cfg_len` in $clog2(DEPTH)+1: number of samples to record; latched on `arm`.
- `cfg_decim` in 8: keep 1 of every cfg_decim+1 valid snapshots; latched on `arm`.
- `out_data` out CNT_W: popcount of the stored sample.
- `out_valid` out 1: stream valid.
- `out_ready` in 1: stream ready.
- `out_last` out 1: marks the final sample of the trace.
- `busy` out 1: high in any state other than IDLE.
- `done` out 1: one-cycle pulse after the last sample is handed off.

## Operation
- States are IDLE, ARMED, CAPTURE, FLUSH and DRAIN.
- **IDLE to ARMED:** on `arm`.
  - Latch `len_q` = cfg_len. If cfg_len is 0 or greater than DEPTH, `len_q` = DEPTH.
  - Latch `decim_q` = cfg_decim.
  - Clear the sample, write and read counters.
  - `arm` is ignored in any state other than IDLE.
- **Trigger synchronisation:** `esp_trigger` passes through a 2-flop synchroniser. A third flop holds the previous value; this runs in every state.
  - `trig_rise` = sync2 & ~prev.
  - A trigger that is already high when `arm` arrives does not start a capture; a fresh rising edge is required.
- **ARMED to CAPTURE:** on `trig_rise`. The decimation counter is cleared.
- **In CAPTURE:** on each cycle with `tdc_valid`=1:
  - If the decimation counter is 0, the snapshot is accepted and `acc_cnt` increments.
  - The decimation counter counts 0..decim_q and then wraps to 0.
  - Accepted snapshots enter a 2-stage popcount pipeline. Stage 1 computes eight 8-bit partial sums; stage 2 sums them.
  - The result is zero-extended to CNT_W and written to the buffer at `wr_ptr`, which then increments.
- **CAPTURE to FLUSH:** on the cycle in which acceptance number `len_q` occurs. No further snapshots are accepted.
- **FLUSH to DRAIN:** once the pipeline is empty (`wr_ptr` == `len_q`), which takes at most 2 cycles.
- **In DRAIN:** the buffer uses a synchronous read with 1-cycle latency and feeds a 1-entry output register with prefetch.
  - Entries are presented in write order.
  - `out_last` = 1 only on entry `len_q`-1.
- **DRAIN to IDLE:** on the cycle after the handshake of the `out_last` entry. `done` pulses for 1 cycle.
- **abort:** from any state, the next state is IDLE.
  - `out_valid`, `out_last` and `busy` are 0 on the following cycle.
  - The pipeline is flushed and `done` is not pulsed.
  - If `abort` and `arm` occur in the same cycle, `abort` wins.
- **tdc_valid gaps:** low `tdc_valid` does not advance the decimation counter or `acc_cnt`.
- **Buffer contents:** not cleared by reset or abort. Only entries 0..len_q-1 of the current trace are ever read.

## Timing
- **Reset values:** `out_data`=0, `out_valid`=0, `out_last`=0, `busy`=0, `done`=0. State is IDLE, and all counters and synchroniser flops are 0.
- **Reset mid-operation:** all of the above take effect immediately and asynchronously, and no partial stream continues.
- **Trigger latency:** if `esp_trigger` rises before clock edge k, the state is CAPTURE from edge k+3. The first snapshot eligible for acceptance is the one sampled at edge k+4.
- **Accept to write:** 2 cycles from a snapshot being accepted to its buffer write.
- **First output:** `out_valid` rises 2 cycles after entering DRAIN.
- **Throughput:** with `out_ready` held at 1, one sample per cycle. `out_valid` is never withdrawn without a handshake, except on abort or reset.
- **Stability under backpressure:** while `out_valid`=1 and `out_ready`=0, `out_data` and `out_last` hold stable.
- **busy:** rises the cycle after `arm` and falls in the same cycle that `done` pulses.

## Test plan
- **Basic trace:** arm with cfg_len=4 and cfg_decim=0; present valid snapshots 64'hF, 64'hFF, 64'hFFF, all-ones, then pulse the trigger, with `out_ready`=1. Required response: stream 4, 8, 12, 64; `out_last` only on the 64; one `done` pulse; `busy` low afterwards.
- **Decimation:** cfg_len=3, cfg_decim=2, continuous valid snapshots whose popcounts are 0, 1, 2, …, starting from the first eligible cycle. Required response: stream 0, 3, 6.
- **Backpressure:** run the basic trace with `out_ready` = 1,0,0,1,0,1,… Required response: no duplicated or lost samples; `out_data` and `out_last` stable while stalled.
- **Trigger qualification:**
  - Trigger pulses while IDLE: no state change.
  - Trigger already high at `arm`: stays ARMED until the trigger falls and rises again; capture then proceeds normally.
- **Abort and reset:**
  - `abort` in CAPTURE after 2 acceptances: IDLE on the next cycle, `out_valid` stays 0, no `done`.
  - `rst_n` low mid-DRAIN: all outputs 0 immediately.
- **Length boundary:** cfg_len=0 with DEPTH=1024. Required response: exactly 1024 samples, `out_last` on the 1024th, the write pointer wraps cleanly, and the next `arm` starts again at entry 0.
